// File: rtl/perf_counter_responder_pkg.sv
// ----------------------------------------------------------------------------
// perf_counter_responder_pkg
// Shared types and constants for the performance-counter window.
//   PERF_BASE_ADDR  : first address of the 16-entry counter window
//   perf_cnt_idx_t  : window slot index (address[3:0])
//   perf_ctrl_t     : control register layout, bit0 freeze, bit1 clear_all
//   perf_slot_idx() : maps physical counter number (0..8) to its window slot
// ----------------------------------------------------------------------------
package perf_counter_responder_pkg;

    localparam int unsigned PERF_WIDTH     = 16;
    localparam logic [15:0] PERF_BASE_ADDR = 16'hFFF0;
    localparam int          PERF_NUM_CNT   = 9;

    typedef enum logic [3:0] {
        IDX_L2_MISS = 4'h0,
        IDX_L2_HIT  = 4'h1,
        IDX_IC_MISS = 4'h2,
        IDX_IC_HIT  = 4'h3,
        IDX_DC_MISS = 4'h4,
        IDX_DC_HIT  = 4'h5,
        IDX_CTRL    = 4'hC,
        IDX_INSTR   = 4'hD,
        IDX_BRANCH  = 4'hE,
        IDX_STALL   = 4'hF
    } perf_cnt_idx_t;

    localparam logic [3:0] PERF_CTRL_IDX = IDX_CTRL;

    // Packed so that freeze lands on bit 0 and clear_all on bit 1.
    typedef struct packed {
        logic clear_all;
        logic freeze;
    } perf_ctrl_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } perf_state_t;

    function automatic perf_cnt_idx_t perf_slot_idx(input int k);
        case (k)
            0:       return IDX_L2_MISS;
            1:       return IDX_L2_HIT;
            2:       return IDX_IC_MISS;
            3:       return IDX_IC_HIT;
            4:       return IDX_DC_MISS;
            5:       return IDX_DC_HIT;
            6:       return IDX_INSTR;
            7:       return IDX_BRANCH;
            default: return IDX_STALL;
        endcase
    endfunction

endpackage

// File: rtl/perf_counter_responder_counter.sv
// ----------------------------------------------------------------------------
// perf_counter
// One performance counter with clear, byte-lane load and increment.
// Priority: clear > load > increment (a load on the same edge drops the event).
// A load with no byte lane enabled is not a load, so the event still counts.
// Optional macro PERF_CNT_SATURATE_EN: increments stop at all-ones instead of
// wrapping; loads may still lower the value.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   clear_i         force counter to zero
//   load_i, be_i    load request and byte-lane enables ([0]=7:0, [1]=upper)
//   wdata_i         load data
//   inc_i           increment by one
//   cnt_o           current count
// ----------------------------------------------------------------------------
module perf_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [1:0]       be_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i && (be_i != 2'b00)) begin
            if (be_i[0]) cnt_d[7:0]       = wdata_i[7:0];
            if (be_i[1]) cnt_d[WIDTH-1:8] = wdata_i[WIDTH-1:8];
        end else if (inc_i) begin
`ifdef PERF_CNT_SATURATE_EN
            if (cnt_q != '1) cnt_d = cnt_q + ONE;
`else
            cnt_d = cnt_q + ONE;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_counter_responder.sv
// ----------------------------------------------------------------------------
// perf_counter_responder
// Memory-mapped responder for the perf counter window base_addr..base_addr+15.
// Nine event counters, a control register (bit0 freeze R/W, bit1 clear_all
// write-one self-clearing) and a two-state IDLE/RESP handshake FSM giving one
// cycle of latency. Reads return the pre-increment value and are held until
// the next read. Both mem_read and mem_write high is treated as a write.
// Optional macro PERF_CNT_SATURATE_EN (passed to perf_counter): saturate at
// 16'hFFFF instead of wrapping.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   mem_address/read/write/wdata     CPU request, held until mem_resp
//   mem_byte_enable                  write lanes [0]=7:0, [1]=15:8
//   load_pc, is_branch               retire events
//   l2/icache/dcache hit/miss        one-cycle event pulses
//   counter_space                    mem_address falls in the window
//   mem_resp, mem_rdata              completion pulse and read data
// ----------------------------------------------------------------------------
module perf_counter_responder
    import perf_counter_responder_pkg::*;
#(
    parameter int unsigned width     = PERF_WIDTH,
    parameter logic [15:0] base_addr = PERF_BASE_ADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      mem_address,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [width-1:0] mem_wdata,
    input  logic [1:0]       mem_byte_enable,
    input  logic             load_pc,
    input  logic             is_branch,
    input  logic             l2_hit,
    input  logic             l2_miss,
    input  logic             icache_hit,
    input  logic             icache_miss,
    input  logic             dcache_hit,
    input  logic             dcache_miss,
    output logic             counter_space,
    output logic             mem_resp,
    output logic [width-1:0] mem_rdata
);

    perf_state_t      state_q;
    logic             mem_resp_q;
    logic [width-1:0] rdata_q;
    logic             freeze_q;

    logic [3:0]              idx;
    logic                    access;
    logic                    wr_acc;
    logic                    ctrl_sel;
    logic                    clear_all;
    perf_ctrl_t              ctrl_wr;
    logic [PERF_NUM_CNT-1:0] ev;
    logic [width-1:0]        cnt [PERF_NUM_CNT];
    logic [width-1:0]        rd_mux;

    assign counter_space = (mem_address >= base_addr);
    assign idx           = mem_address[3:0];
    assign access        = (state_q == S_IDLE) && counter_space && (mem_read || mem_write);
    assign wr_acc        = access && mem_write;
    assign ctrl_wr       = perf_ctrl_t'(mem_wdata[1:0]);
    assign ctrl_sel      = wr_acc && (idx == PERF_CTRL_IDX) && mem_byte_enable[0];
    assign clear_all     = ctrl_sel && ctrl_wr.clear_all;

    // Event order follows perf_slot_idx(): counter k is fed by ev[k].
    assign ev = {!load_pc, load_pc && is_branch, load_pc,
                 dcache_hit, dcache_miss, icache_hit, icache_miss, l2_hit, l2_miss};

    for (genvar k = 0; k < PERF_NUM_CNT; k++) begin : g_cnt
        perf_counter #(
            .WIDTH(width)
        ) u_cnt (
            .clk_i  (clk),
            .rst_i  (reset),
            .clear_i(clear_all),
            .load_i (wr_acc && (idx == perf_slot_idx(k))),
            .be_i   (mem_byte_enable),
            .wdata_i(mem_wdata),
            .inc_i  (ev[k] && !freeze_q),
            .cnt_o  (cnt[k])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < PERF_NUM_CNT; k++) begin
            if (idx == perf_slot_idx(k)) rd_mux = cnt[k];
        end
        if (idx == PERF_CTRL_IDX) rd_mux = {{(width-1){1'b0}}, freeze_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mem_resp_q <= 1'b0;
            rdata_q    <= '0;
            freeze_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access) begin
                        state_q    <= S_RESP;
                        mem_resp_q <= 1'b1;
                        if (!mem_write) rdata_q  <= rd_mux;
                        if (ctrl_sel)   freeze_q <= ctrl_wr.freeze;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    mem_resp_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_resp  = mem_resp_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_perf_counter_responder.sv
module tb_perf_counter_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_address = 16'h0000;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_wdata = 16'h0000;
    logic [1:0]  mem_byte_enable = 2'b00;
    logic        load_pc = 1'b0;
    logic        is_branch = 1'b0;
    logic        l2_hit = 1'b0, l2_miss = 1'b0;
    logic        icache_hit = 1'b0, icache_miss = 1'b0;
    logic        dcache_hit = 1'b0, dcache_miss = 1'b0;
    logic        counter_space;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    perf_counter_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .load_pc        (load_pc),
        .is_branch      (is_branch),
        .l2_hit         (l2_hit),
        .l2_miss        (l2_miss),
        .icache_hit     (icache_hit),
        .icache_miss    (icache_miss),
        .dcache_hit     (dcache_hit),
        .dcache_miss    (dcache_miss),
        .counter_space  (counter_space),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Window slots 0-5 and 13-15 are counters, 12 is control, the rest read 0.
    logic [15:0] m_cnt [16];
    logic        m_freeze, m_busy, m_resp;
    logic [15:0] m_rdata;
    bit          m_valid = 1'b0;

    function automatic bit is_cnt(input int i);
        return (i <= 5) || (i >= 13);
    endfunction

    function automatic bit ev_of(input int i);
        case (i)
            0:  return l2_miss;
            1:  return l2_hit;
            2:  return icache_miss;
            3:  return icache_hit;
            4:  return dcache_miss;
            5:  return dcache_hit;
            13: return load_pc;
            14: return load_pc && is_branch;
            15: return !load_pc;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] bump(input logic [15:0] v);
`ifdef PERF_CNT_SATURATE_EN
        return (v == 16'hFFFF) ? v : v + 16'd1;
`else
        return v + 16'd1;
`endif
    endfunction

    always @(posedge clk) begin
        logic [15:0] nxt [16];
        bit          acc;
        int          a;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_cnt[i] <= 16'h0;
            m_freeze <= 1'b0;
            m_busy   <= 1'b0;
            m_resp   <= 1'b0;
            m_rdata  <= 16'h0;
            m_valid  <= 1'b1;
        end else begin
            acc = !m_busy && (mem_address >= 16'hFFF0) && (mem_read || mem_write);
            a   = int'(mem_address[3:0]);
            for (int i = 0; i < 16; i++) begin
                nxt[i] = m_cnt[i];
                if (is_cnt(i) && ev_of(i) && !m_freeze) nxt[i] = bump(m_cnt[i]);
            end
            if (acc && mem_write) begin
                if (a == 12) begin
                    if (mem_byte_enable[0]) begin
                        m_freeze <= mem_wdata[0];
                        if (mem_wdata[1]) for (int i = 0; i < 16; i++) nxt[i] = 16'h0;
                    end
                end else if (is_cnt(a) && mem_byte_enable != 2'b00) begin
                    nxt[a] = m_cnt[a];
                    if (mem_byte_enable[0]) nxt[a][7:0]  = mem_wdata[7:0];
                    if (mem_byte_enable[1]) nxt[a][15:8] = mem_wdata[15:8];
                end
            end
            if (acc && !mem_write)
                m_rdata <= (a == 12) ? {15'h0, m_freeze} : (is_cnt(a) ? m_cnt[a] : 16'h0);
            m_cnt  <= nxt;
            m_resp <= acc;
            m_busy <= acc;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_resp",  {15'h0, mem_resp}, {15'h0, m_resp});
            chk("model_rdata", mem_rdata, m_rdata);
            chk("model_space", {15'h0, counter_space}, {15'h0, (mem_address >= 16'hFFF0)});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_read(input logic [15:0] addr, input logic [15:0] exp,
                           input string name, output int lat);
        int n = 0;
        mem_address = addr;
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_resp && n < 20);
        lat = n;
        chk({name, "_resp"}, {15'h0, mem_resp}, 16'h0001);
        chk(name, mem_rdata, exp);
        @(posedge clk);
        #1 mem_read = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
        int lat;
        do_read(addr, exp, name, lat);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data,
                            input logic [1:0] be, input bit l2pulse, input string name);
        int n = 0;
        mem_address     = addr;
        mem_wdata       = data;
        mem_byte_enable = be;
        mem_write       = 1'b1;
        mem_read        = 1'b0;
        l2_miss         = l2pulse;
        @(posedge clk);
        #1 l2_miss = 1'b0;
        while (!mem_resp && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_resp"}, {15'h0, mem_resp}, 16'h0001);
        @(posedge clk);
        #1 mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit active;
        int hold;

        // 1: reset state, five retirements, read instr counter
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp",  {15'h0, mem_resp}, 16'h0000);
        chk("reset_rdata", mem_rdata, 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
        load_pc = 1'b1;
        repeat (5) @(posedge clk);
        #1 load_pc = 1'b0;
        do_read(16'hFFFD, 16'h0005, "instr5", lat);
        chk("latency", 16'(lat), 16'd2);

        // 2: byte-lane writes
        do_write(16'hFFF2, 16'h00AB, 2'b11, 1'b0, "ic_pre");
        rd(16'hFFF2, 16'h00AB, "ic_pre_rd");
        do_write(16'hFFF2, 16'h1234, 2'b01, 1'b0, "ic_lo");
        rd(16'hFFF2, 16'h0034, "ic_lo_rd");
        do_write(16'hFFF2, 16'hBEEF, 2'b11, 1'b0, "ic_full");
        rd(16'hFFF2, 16'hBEEF, "ic_full_rd");
        do_write(16'hFFF2, 16'h5555, 2'b00, 1'b0, "ic_none");
        rd(16'hFFF2, 16'hBEEF, "ic_none_rd");

        // 3: wrap / saturate on the stall counter
        load_pc = 1'b1;
        do_write(16'hFFFF, 16'hFFFE, 2'b11, 1'b0, "stall_pre");
        load_pc = 1'b0;
        repeat (2) @(posedge clk);
        #1 load_pc = 1'b1;
`ifdef PERF_CNT_SATURATE_EN
        rd(16'hFFFF, 16'hFFFF, "stall_sat");
`else
        rd(16'hFFFF, 16'h0000, "stall_wrap");
`endif

        // 4: freeze then clear_all
        do_write(16'hFFF5, 16'h0007, 2'b11, 1'b0, "dch_pre");
        do_write(16'hFFFC, 16'h0001, 2'b11, 1'b0, "freeze");
        rd(16'hFFFC, 16'h0001, "ctrl_frozen");
        dcache_hit = 1'b1;
        repeat (3) @(posedge clk);
        #1 dcache_hit = 1'b0;
        rd(16'hFFF5, 16'h0007, "dch_frozen");
        do_write(16'hFFFC, 16'h0002, 2'b11, 1'b0, "clear_all");
        rd(16'hFFF5, 16'h0000, "dch_clr");
        rd(16'hFFF2, 16'h0000, "ic_clr");
        rd(16'hFFFC, 16'h0000, "ctrl_rd");

        // 5: write beats simultaneous event; hole reads zero
        do_write(16'hFFF0, 16'h0010, 2'b11, 1'b1, "l2m_wr");
        rd(16'hFFF0, 16'h0010, "l2m_wins");
        rd(16'hFFF8, 16'h0000, "hole");

        // 6: outside window, then reset during RESP
        load_pc     = 1'b0;
        mem_address = 16'h1000;
        mem_read    = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("out_space", {15'h0, counter_space}, 16'h0000);
            chk("out_resp",  {15'h0, mem_resp}, 16'h0000);
        end
        @(posedge clk);
        #1 mem_address = 16'hFFFD;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("in_resp", {15'h0, mem_resp}, 16'h0001);
        @(posedge clk);
        #1 mem_read = 1'b0;
        @(negedge clk);
        chk("rst_resp",  {15'h0, mem_resp}, 16'h0000);
        chk("rst_rdata", mem_rdata, 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
        rd(16'hFFF0, 16'h0000, "rst_l2m");
        rd(16'hFFFD, 16'h0000, "rst_instr");
        rd(16'hFFFC, 16'h0000, "rst_ctrl");

        // random phase: events and accesses checked against the model
        active = 1'b0;
        hold   = 0;
        for (int c = 0; c < 500; c++) begin
            l2_hit      = ($urandom_range(0, 3) == 0);
            l2_miss     = ($urandom_range(0, 3) == 0);
            icache_hit  = ($urandom_range(0, 1) == 0);
            icache_miss = ($urandom_range(0, 3) == 0);
            dcache_hit  = ($urandom_range(0, 1) == 0);
            dcache_miss = ($urandom_range(0, 3) == 0);
            load_pc     = ($urandom_range(0, 2) != 0);
            is_branch   = ($urandom_range(0, 2) == 0);
            if (active) begin
                hold++;
                if (mem_resp || hold >= 4) begin
                    active    = 1'b0;
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                int kind;
                active = 1'b1;
                hold   = 0;
                if ($urandom_range(0, 9) == 0) mem_address = 16'(16'h1000 + $urandom_range(0, 255));
                else mem_address = {12'hFFF, 4'($urandom_range(0, 15))};
                mem_wdata       = 16'($urandom());
                if (mem_address[3:0] == 4'hC)
                    mem_wdata = {14'h0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0)};
                mem_byte_enable = 2'($urandom_range(0, 3));
                kind = $urandom_range(0, 4);
                mem_read  = (kind <= 2) || (kind == 4);
                mem_write = (kind >= 3);
            end
            @(posedge clk);
            #1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
